// File: rtl/hx8352_pkg.sv
// hx8352_pkg: HX8352 bus receiver register indices, bus widths and state type.
package hx8352_pkg;

    localparam int DATA_W  = 16;
    localparam int COORD_W = 9;
    localparam int IDX_W   = 8;

    localparam logic [IDX_W-1:0] IDX_SC_H = 8'h02;
    localparam logic [IDX_W-1:0] IDX_SC_L = 8'h03;
    localparam logic [IDX_W-1:0] IDX_EC_H = 8'h04;
    localparam logic [IDX_W-1:0] IDX_EC_L = 8'h05;
    localparam logic [IDX_W-1:0] IDX_SP_H = 8'h06;
    localparam logic [IDX_W-1:0] IDX_SP_L = 8'h07;
    localparam logic [IDX_W-1:0] IDX_EP_H = 8'h08;
    localparam logic [IDX_W-1:0] IDX_EP_L = 8'h09;
    localparam logic [IDX_W-1:0] IDX_GRAM = 8'h22;

    typedef enum logic {ST_REG, ST_GRAM} bus_state_t;

endpackage

// File: rtl/hx8352_bus_sync.sv
// hx8352_bus_sync: synchronises the 8080 bus and emits a registered write event
// on each synced WR rising edge while CS is low, with RS/DATA from the same stage.
module hx8352_bus_sync
    import hx8352_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rs,
    input  logic              wr,
    input  logic [DATA_W-1:0] data,
    output logic              ev,
    output logic              ev_rs,
    output logic [DATA_W-1:0] ev_data
);

    logic [STAGES-1:0]             cs_q, rs_q, wr_q;
    logic [STAGES-1:0][DATA_W-1:0] data_q;
    logic                          wr_d;

    // WR and CS reset high so an edge in flight at reset release is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q    <= '1;
            wr_q    <= '1;
            rs_q    <= '0;
            data_q  <= '0;
            wr_d    <= 1'b1;
            ev      <= 1'b0;
            ev_rs   <= 1'b0;
            ev_data <= '0;
        end else begin
            cs_q    <= {cs_q[STAGES-2:0], cs};
            wr_q    <= {wr_q[STAGES-2:0], wr};
            rs_q    <= {rs_q[STAGES-2:0], rs};
            data_q  <= {data_q[STAGES-2:0], data};
            wr_d    <= wr_q[STAGES-1];
            ev      <= wr_q[STAGES-1] && !wr_d && !cs_q[STAGES-1];
            ev_rs   <= rs_q[STAGES-1];
            ev_data <= data_q[STAGES-1];
        end
    end

endmodule

// File: rtl/hx8352_bus_receiver.sv
// hx8352_bus_receiver: HX8352 panel-side bus endpoint decoding index/register
// writes and walking the GRAM cursor over the active window.
module hx8352_bus_receiver
    import hx8352_pkg::*;
#(
    parameter int H_RES       = 240,
    parameter int V_RES       = 400,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lcd_cs,
    input  logic               lcd_rs,
    input  logic               lcd_wr,
    input  logic               lcd_rd,
    input  logic [DATA_W-1:0]  data_bus,
    output logic               reg_wr_valid,
    output logic [IDX_W-1:0]   reg_index,
    output logic [DATA_W-1:0]  reg_data,
    output logic               pixel_valid,
    output logic [DATA_W-1:0]  pixel_data,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    logic               ev, ev_rs, unused_rd;
    logic [DATA_W-1:0]  ev_data;
    bus_state_t         state_q, state_d;
    logic [COORD_W-1:0] sc, ec, sp, ep, cx, cy, x_nxt, y_nxt;
    logic               x_end, y_end;

    assign unused_rd = lcd_rd;

    hx8352_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .cs      (lcd_cs),
        .rs      (lcd_rs),
        .wr      (lcd_wr),
        .data    (data_bus),
        .ev      (ev),
        .ev_rs   (ev_rs),
        .ev_data (ev_data)
    );

    always_comb begin
        state_d = state_q;
        if (ev && !ev_rs)
            state_d = (ev_data[IDX_W-1:0] == IDX_GRAM) ? ST_GRAM : ST_REG;
    end

    // The panel clamp also ends a line, which is what makes SC>EC wrap at X_MAX
    always_comb begin
        x_end = (cx == ec) || (cx == X_MAX);
        y_end = (cy == ep) || (cy == Y_MAX);
        x_nxt = x_end ? sc : cx + 1'b1;
        y_nxt = x_end ? (y_end ? sp : cy + 1'b1) : cy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_REG;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_wr_valid <= 1'b0;
            reg_index    <= '0;
            reg_data     <= '0;
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            frame_done   <= 1'b0;
            sc           <= '0;
            ec           <= X_MAX;
            sp           <= '0;
            ep           <= Y_MAX;
            cx           <= '0;
            cy           <= '0;
        end else begin
            reg_wr_valid <= 1'b0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            if (ev && !ev_rs) begin
                reg_index <= ev_data[IDX_W-1:0];
                if (ev_data[IDX_W-1:0] == IDX_GRAM) begin
                    cx <= sc;
                    cy <= sp;
                end
            end else if (ev && state_q == ST_GRAM) begin
                pixel_valid <= 1'b1;
                pixel_data  <= ev_data;
                pixel_x     <= cx;
                pixel_y     <= cy;
                frame_done  <= x_end && y_end;
                cx          <= x_nxt;
                cy          <= y_nxt;
            end else if (ev) begin
                reg_wr_valid <= 1'b1;
                reg_data     <= ev_data;
                case (reg_index)
                    IDX_SC_H: sc[8]   <= ev_data[0];
                    IDX_SC_L: sc[7:0] <= ev_data[7:0];
                    IDX_EC_H: ec[8]   <= ev_data[0];
                    IDX_EC_L: ec[7:0] <= ev_data[7:0];
                    IDX_SP_H: sp[8]   <= ev_data[0];
                    IDX_SP_L: sp[7:0] <= ev_data[7:0];
                    IDX_EP_H: ep[8]   <= ev_data[0];
                    IDX_EP_L: ep[7:0] <= ev_data[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/hx8352_bus_receiver.md
Name: hx8352_bus_receiver

Overview:
- LCD-side endpoint of the HX8352 8080-style parallel write bus: emulates the panel's bus interface inside the FPGA.
- Samples CS/RS/WR/DATA from an external or internal driver and decodes index (command) writes and register data writes.
- Runs the GRAM write cursor over the active window and emits one pixel strobe with coordinates per GRAM data word.
- Feeds a framebuffer writer or scoreboard; serves as the loopback target for the LCD controller in hardware tests.

Parameters:
- H_RES, 240, panel width in pixels; reset value of column end is H_RES-1
- V_RES, 400, panel height in pixels; reset value of row end is V_RES-1
- SYNC_STAGES, 2, flip-flops in each input synchroniser (minimum 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-low
- lcd_cs  in  1  chip select, active-low
- lcd_rs  in  1  0 = index/command word, 1 = data word
- lcd_wr  in  1  write strobe, active-low; word captured on rising edge
- lcd_rd  in  1  read strobe; ignored, no bus drive
- data_bus  in  16  parallel data
- reg_wr_valid  out  1  one-cycle pulse on a non-GRAM register data write
- reg_index  out  8  current index register
- reg_data  out  16  data word of the last register write
- pixel_valid  out  1  one-cycle pulse per GRAM data word
- pixel_data  out  16  RGB565 pixel
- pixel_x  out  9  column of the pixel
- pixel_y  out  9  row of the pixel
- frame_done  out  1  pulse coincident with pixel_valid for the last pixel of the window

Behaviour:
- Reset: asserting rst (rst=0) drives all outputs to 0 immediately. Index register = 0x00. Window: SC=0, EC=H_RES-1, SP=0, EP=V_RES-1. Cursor = (0,0).
- Synchronisation: lcd_cs, lcd_rs, lcd_wr and data_bus each pass through SYNC_STAGES flops.
- Write event: synced WR is 1 in the current cycle, was 0 in the previous cycle, and synced CS is 0. RS and DATA are taken from the same synced stage.
- Bus timing requirement on the driver: WR low ≥ 3 clk, WR high ≥ 3 clk, DATA/RS stable from WR fall until 3 clk after WR rise.
- Latency: every output pulse appears exactly 1 clk after the write-event cycle; that is SYNC_STAGES+2 clk after WR rises at the pin.
- RS=0 write: index register <= data[7:0]. No output pulse.
  - If the index is 0x22, enter GRAM state and set cursor = (SC,SP).
  - Any other index leaves GRAM state.
- RS=1 write in register state: reg_data <= data, reg_wr_valid pulses. Window registers update:
  - 0x02 SC[8], 0x03 SC[7:0]
  - 0x04 EC[8], 0x05 EC[7:0]
  - 0x06 SP[8], 0x07 SP[7:0]
  - 0x08 EP[8], 0x09 EP[7:0]
  - Window changes never move the cursor; the cursor is reloaded only by an index write of 0x22.
- RS=1 write in GRAM state: pixel_valid pulses with pixel_data=data and the current cursor, then the cursor advances:
  - x==EC or x==H_RES-1: x <= SC, then y advances.
  - Otherwise: x <= x+1.
  - y advance: if y==EP or y==V_RES-1, y <= SP and frame_done pulses together with this pixel; otherwise y <= y+1.
  - Degenerate window (SC>EC): x runs to H_RES-1, then wraps to SC.
- CS deasserted: write events are ignored. Index register, state and cursor are retained across CS toggles.
- WR edge while CS high: ignored, no state change.
- RD activity: no effect; the block never drives data_bus.
- Reset mid-transfer: returns to reset values. A WR rising edge already in the synchroniser at reset release is lost, not replayed: synchroniser flops reset to WR=1 and CS=1.
- Back-to-back writes at minimum timing produce distinct pulses with no drops. There is no internal buffering; downstream must accept one pulse per event.

Decomposition:
- Package hx8352_pkg: index constants IDX_SC_H=0x02 … IDX_EP_L=0x09 and IDX_GRAM=0x22, plus the pixel/coordinate widths.
- Sub-module hx8352_bus_sync: parameterised synchroniser for CS/RS/WR/DATA plus WR rising-edge detector. Outputs a one-cycle write event with the aligned rs/data.
- Top level holds the index register, window registers, GRAM state and cursor counters.

Test Plan:
- Reset, then index 0x22 and data 0xF800, 0x07E0 -> pixels (0,0)=0xF800 and (1,0)=0x07E0, each at SYNC_STAGES+2 clk after WR rise; frame_done=0.
- Window SC=10, EC=11, SP=5, EP=6 (via 0x02–0x09), then 0x22 and 4 data words -> coordinates (10,5),(11,5),(10,6),(11,6); frame_done only on the 4th; a 5th word lands at (10,5).
- Reset window, 0x22, then 96000 words -> last pixel at (239,399) with frame_done; the next pixel is at (0,0).
- Index 0x05, data 0x00AB -> reg_wr_valid pulse, reg_index=0x05, reg_data=0x00AB, no pixel_valid; EC low byte becomes 0xAB.
- WR pulses with CS high, and RD pulses with CS low -> no output pulses, cursor unchanged.
- rst=0 asserted midway through a WR-low phase, released before WR rises -> all outputs 0, index 0x00, no spurious pulse after release.
